// File: rtl/franco_xor_pkg.sv
// Shared state encoding, default widths and the key-repeat helper for the XOR cipher receiver.
// Pure declarations: no latency, no flow control.
package franco_xor_pkg;

    localparam int DEF_KEY_SIZE = 4;
    localparam int DEF_MSG_SIZE = 8;

    typedef enum logic [1:0] {
        S_NOKEY   = 2'd0,
        S_LOADKEY = 2'd1,
        S_READY   = 2'd2,
        S_RECV    = 2'd3
    } state_e;

    function automatic logic [DEF_MSG_SIZE-1:0] repeat_key(input logic [DEF_KEY_SIZE-1:0] key);
        return {DEF_MSG_SIZE/DEF_KEY_SIZE{key}};
    endfunction

endpackage

// File: rtl/franco_xor_shift_in.sv
// Serial-in MSB-first shift register with bit counter; oDone flags the WIDTH-th bit combinationally.
// oNext holds the full word including the current bit, so the caller captures it on the same edge; no backpressure.
module franco_xor_shift_in #(
    parameter int WIDTH = 8
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iEn,
    input  logic             iClr,
    input  logic             iBitVld,
    input  logic             iBit,
    output logic [WIDTH-1:0] oNext,
    output logic             oDone
);
    localparam int CW = $clog2(WIDTH + 1);

    // Only WIDTH-1 bits are stored: the last bit of a word is consumed straight from oNext.
    logic [WIDTH-2:0] shiftReg;
    logic [CW-1:0]    bitCount;

    assign oNext = {shiftReg, iBit};
    assign oDone = iEn && !iClr && iBitVld && (bitCount == CW'(WIDTH - 1));

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            shiftReg <= '0;
            bitCount <= '0;
        end else if (iEn) begin
            if (iClr) begin
                shiftReg <= '0;
                bitCount <= '0;
            end else if (iBitVld) begin
                shiftReg <= oNext[WIDTH-2:0];
                bitCount <= oDone ? '0 : bitCount + 1'b1;
            end
        end
    end

endmodule

// File: rtl/franco_xor_decrypt_rx.sv
// Serial XOR cipher receiver: loads a key, captures ciphertext frames, emits plaintext with a 1-cycle oValid.
// Plaintext appears the cycle after the last ciphertext bit; no backpressure, frames may run back-to-back.
module franco_xor_decrypt_rx
    import franco_xor_pkg::*;
#(
    parameter int KEY_SIZE = DEF_KEY_SIZE,
    parameter int MSG_SIZE = DEF_MSG_SIZE
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iEn,
    input  logic                iData_in,
    input  logic                iLoad_key,
    input  logic                iValid,
    output logic [MSG_SIZE-1:0] oPlaintext,
    output logic                oValid,
    output logic                oKey_ready,
    output logic                oBusy,
    output logic                oDrop
);
    state_e                state;
    logic                  loadDone;
    logic [KEY_SIZE-1:0]   keyReg;
    logic [KEY_SIZE-1:0]   keyNext;
    logic [MSG_SIZE-1:0]   frameNext;
    logic [MSG_SIZE-1:0]   keyRep;
    logic                  keyDone;
    logic                  frameDone;
    logic                  frameBitVld;

    assign frameBitVld = iValid && (state == S_READY || state == S_RECV);

    // loadDone masks key bits that keep arriving after a complete key until iLoad_key falls.
    franco_xor_shift_in #(.WIDTH(KEY_SIZE)) uKeyShift (
        .iClk    (iClk),
        .iRst    (iRst),
        .iEn     (iEn),
        .iClr    (!iLoad_key),
        .iBitVld (iLoad_key && !loadDone),
        .iBit    (iData_in),
        .oNext   (keyNext),
        .oDone   (keyDone)
    );

    franco_xor_shift_in #(.WIDTH(MSG_SIZE)) uFrameShift (
        .iClk    (iClk),
        .iRst    (iRst),
        .iEn     (iEn),
        .iClr    (iLoad_key),
        .iBitVld (frameBitVld),
        .iBit    (iData_in),
        .oNext   (frameNext),
        .oDone   (frameDone)
    );

    generate
        if (KEY_SIZE == DEF_KEY_SIZE && MSG_SIZE == DEF_MSG_SIZE) begin : gRepPkg
            assign keyRep = repeat_key(keyReg);
        end else begin : gRepLocal
            assign keyRep = {MSG_SIZE/KEY_SIZE{keyReg}};
        end
    endgenerate

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state      <= S_NOKEY;
            loadDone   <= 1'b0;
            keyReg     <= '0;
            oPlaintext <= '0;
            oValid     <= 1'b0;
            oKey_ready <= 1'b0;
            oBusy      <= 1'b0;
            oDrop      <= 1'b0;
        end else begin
            oValid <= 1'b0;
            if (iEn) begin
                if (iLoad_key) begin
                    // Key load wins over ciphertext: any frame in progress is abandoned.
                    oBusy <= 1'b0;
                    if (iValid) oDrop <= 1'b1;
                    if (keyDone) begin
                        keyReg     <= keyNext;
                        oKey_ready <= 1'b1;
                        oDrop      <= 1'b0;
                        loadDone   <= 1'b1;
                        state      <= S_READY;
                    end else if (!loadDone) begin
                        state <= S_LOADKEY;
                    end
                end else begin
                    loadDone <= 1'b0;
                    unique case (state)
                        S_NOKEY: begin
                            if (iValid) oDrop <= 1'b1;
                        end
                        S_LOADKEY: begin
                            if (iValid) oDrop <= 1'b1;
                            state <= oKey_ready ? S_READY : S_NOKEY;
                        end
                        S_READY, S_RECV: begin
                            if (frameDone) begin
                                oPlaintext <= frameNext ^ keyRep;
                                oValid     <= 1'b1;
                                oBusy      <= 1'b0;
                                state      <= S_READY;
                            end else if (iValid) begin
                                oBusy <= 1'b1;
                                state <= S_RECV;
                            end
                        end
                        default: state <= S_NOKEY;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_franco_xor_decrypt_rx.sv
// Bench for franco_xor_decrypt_rx: spec vectors, hand sequences for corner cases, then random traffic vs a bit-level model.
module tb_franco_xor_decrypt_rx;
    localparam int KEY = 4;
    localparam int MSG = 8;

    logic           iClk;
    logic           iRst;
    logic           iEn;
    logic           iData_in;
    logic           iLoad_key;
    logic           iValid;
    logic [MSG-1:0] oPlaintext;
    logic           oValid;
    logic           oKey_ready;
    logic           oBusy;
    logic           oDrop;

    franco_xor_decrypt_rx #(.KEY_SIZE(KEY), .MSG_SIZE(MSG)) dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iEn        (iEn),
        .iData_in   (iData_in),
        .iLoad_key  (iLoad_key),
        .iValid     (iValid),
        .oPlaintext (oPlaintext),
        .oValid     (oValid),
        .oKey_ready (oKey_ready),
        .oBusy      (oBusy),
        .oDrop      (oDrop)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lastValidCyc = 0;
    int validCount = 0;

    // Reference model state: plain integers and flags describing what has been received so far.
    int mKey, mPk, mPkCnt, mFrame, mFCnt, mPt;
    bit mKeyReady, mLatched, mLoading, mValid, mDrop;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int repKey(input int k);
        int r = 0;
        for (int i = 0; i < MSG; i++)
            if (((k >> (i % KEY)) & 1) != 0) r |= (1 << i);
        return r;
    endfunction

    task automatic modelReset();
        mKey = 0; mPk = 0; mPkCnt = 0; mFrame = 0; mFCnt = 0; mPt = 0;
        mKeyReady = 0; mLatched = 0; mLoading = 0; mValid = 0; mDrop = 0;
    endtask

    task automatic modelStep(input bit en, input bit ld, input bit vl, input bit b);
        mValid = 0;
        if (en) begin
            if (ld) begin
                mFCnt = 0; mFrame = 0;
                if (vl) mDrop = 1;
                if (!mLatched) begin
                    mPk = ((mPk << 1) | int'(b)) % (1 << KEY);
                    mPkCnt++;
                    if (mPkCnt == KEY) begin
                        mKey = mPk; mKeyReady = 1; mDrop = 0; mLatched = 1;
                        mPkCnt = 0; mPk = 0;
                    end
                end
                mLoading = !mLatched;
            end else begin
                mLatched = 0; mPkCnt = 0; mPk = 0;
                if (vl) begin
                    if (!mKeyReady || mLoading) mDrop = 1;
                    else begin
                        mFrame = ((mFrame << 1) | int'(b)) % (1 << MSG);
                        mFCnt++;
                        if (mFCnt == MSG) begin
                            mPt = mFrame ^ repKey(mKey);
                            mValid = 1; mFCnt = 0; mFrame = 0;
                        end
                    end
                end
                mLoading = 0;
            end
        end
    endtask

    function automatic int packOuts();
        return (int'(oPlaintext) << 4) | (int'(oValid) << 3) | (int'(oKey_ready) << 2)
             | (int'(oBusy) << 1) | int'(oDrop);
    endfunction

    function automatic int packModel();
        return (mPt << 4) | (int'(mValid) << 3) | (int'(mKeyReady) << 2)
             | (int'(mFCnt != 0) << 1) | int'(mDrop);
    endfunction

    // Called at a negedge: drive, take the edge, compare against the model, return at the next negedge.
    task automatic step(input bit en, input bit ld, input bit vl, input bit b);
        iEn = en; iLoad_key = ld; iValid = vl; iData_in = b;
        @(posedge iClk);
        modelStep(en, ld, vl, b);
        #1;
        cyc++;
        check("outputs_vs_model", packOuts(), packModel());
        if (oValid) begin
            lastValidCyc = cyc;
            validCount++;
        end
        @(negedge iClk);
    endtask

    task automatic sendKey(input logic [KEY-1:0] k);
        for (int i = KEY - 1; i >= 0; i--) step(1, 1, 0, k[i]);
        step(1, 0, 0, 0);
    endtask

    task automatic sendFrame(input logic [MSG-1:0] c);
        for (int i = MSG - 1; i >= 0; i--) step(1, 0, 1, c[i]);
    endtask

    task automatic doReset();
        iRst = 1'b0;
        #2;
        modelReset();
        check("reset_outputs_zero", packOuts(), 0);
        @(negedge iClk);
        iRst = 1'b1;
        iEn = 0; iLoad_key = 0; iValid = 0; iData_in = 0;
    endtask

    typedef struct {
        logic [KEY-1:0] key;
        logic [MSG-1:0] ct;
        logic [MSG-1:0] pt;
    } vec_t;

    vec_t vecs[6];
    logic [MSG-1:0] frameTmp;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c1;
        int loadRun;
        bit en, ld, vl, b;

        vecs[0] = '{key: 4'b1010, ct: 8'b0110_0011, pt: 8'b1100_1001};
        vecs[1] = '{key: 4'h3,    ct: 8'hF6,        pt: 8'hC5};
        vecs[2] = '{key: 4'hF,    ct: 8'hFF,        pt: 8'h00};
        vecs[3] = '{key: 4'h5,    ct: 8'h5A,        pt: 8'h0F};
        vecs[4] = '{key: 4'h0,    ct: 8'hA5,        pt: 8'hA5};
        vecs[5] = '{key: 4'hC,    ct: 8'h3C,        pt: 8'hF0};

        iRst = 1'b0; iEn = 0; iLoad_key = 0; iValid = 0; iData_in = 0;
        modelReset();
        repeat (2) @(negedge iClk);
        check("reset_state", packOuts(), 0);
        iRst = 1'b1;

        // Key ready only after exactly KEY bits.
        for (int i = KEY - 1; i >= 1; i--) step(1, 1, 0, vecs[1].key[i]);
        check("key_not_ready_3_bits", int'(oKey_ready), 0);
        step(1, 1, 0, vecs[1].key[0]);
        check("key_ready_4_bits", int'(oKey_ready), 1);
        step(1, 0, 0, 0);

        foreach (vecs[v]) begin
            sendKey(vecs[v].key);
            validCount = 0;
            sendFrame(vecs[v].ct);
            check("tbl_valid_after_last_bit", int'(oValid), 1);
            check("tbl_plaintext", int'(oPlaintext), int'(vecs[v].pt));
            step(1, 0, 0, 0);
            check("tbl_single_pulse", validCount, 1);
        end

        // Back-to-back frames with key F.
        sendKey(4'hF);
        sendFrame(8'hFF);
        check("b2b_first", int'(oPlaintext), 8'h00);
        c1 = lastValidCyc;
        sendFrame(8'h00);
        check("b2b_second", int'(oPlaintext), 8'hFF);
        check("b2b_spacing", lastValidCyc - c1, 8);

        // Enable stall and iValid gap inside a frame.
        sendKey(4'b1010);
        frameTmp = 8'b0110_0011;
        validCount = 0;
        for (int i = MSG - 1; i >= 5; i--) step(1, 0, 1, frameTmp[i]);
        repeat (3) step(0, 1, 1, 1);
        check("stall_busy_held", int'(oBusy), 1);
        repeat (2) step(1, 0, 0, 1);
        check("gap_no_valid", validCount, 0);
        for (int i = 4; i >= 0; i--) step(1, 0, 1, frameTmp[i]);
        check("stall_plaintext", int'(oPlaintext), 8'hC9);
        check("stall_one_pulse", validCount, 1);

        // Ciphertext before a key, then key load aborting a frame.
        doReset();
        validCount = 0;
        step(1, 0, 1, 1);
        check("nokey_drop", int'(oDrop), 1);
        check("nokey_no_valid", validCount, 0);
        sendKey(4'h3);
        check("drop_cleared_by_key", int'(oDrop), 0);
        for (int i = 0; i < 5; i++) step(1, 0, 1, i[0]);
        check("abort_busy_before", int'(oBusy), 1);
        step(1, 1, 1, 0);
        check("abort_busy_cleared", int'(oBusy), 0);
        check("abort_drop_set", int'(oDrop), 1);
        for (int i = KEY - 2; i >= 0; i--) step(1, 1, 0, (4'h5 >> i) & 1);
        step(1, 0, 0, 0);
        sendFrame(8'h5A);
        check("abort_new_key_pt", int'(oPlaintext), 8'h0F);
        check("abort_no_early_valid", validCount, 1);

        // Reset mid-frame, then a fresh key and frame.
        sendKey(4'hA);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 1);
        doReset();
        sendKey(4'h3);
        sendFrame(8'hF6);
        check("post_reset_pt", int'(oPlaintext), 8'hC5);

        // Random traffic against the model.
        loadRun = 0;
        for (int n = 0; n < 1500; n++) begin
            en = ($urandom_range(0, 9) != 0);
            if (loadRun > 0) begin
                ld = 1; loadRun--;
            end else if ($urandom_range(0, 29) == 0) begin
                ld = 1; loadRun = $urandom_range(1, 6);
            end else ld = 0;
            vl = ($urandom_range(0, 9) < 7);
            b  = 1'($urandom_range(0, 1));
            step(en, ld, vl, b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
